// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the single-port data RAM.
// Build option DMEM_ARBITER_RR_EN selects round-robin; the default build uses fixed priority with port 0 first.
module dmem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 32,
  parameter int IDXW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DWIDTH-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata1,
  output logic              err,
  output logic              ram_en_fetch,
  output logic              ram_en_store,
  output logic [IDXW-1:0]   ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;

  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;

  logic [1:0]        state;
  logic              rd_port;
  logic              rd_oor;
  logic              win;
  logic              take;
  logic              grant;
  logic              sel_we;
  logic              sel_oor;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

`ifdef DMEM_ARBITER_RR_EN
  logic last_grant;

  always_comb begin
    if (req0 && req1) win = ~last_grant;
    else              win = ~req0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= 1'b1;
    else if (take) last_grant <= win;
  end
`else
  always_comb win = ~req0;
`endif

  // take drives the flops; grant adds the reset gate so outputs hold reset values while rst is high
  always_comb begin
    take      = (state == IDLE) && (req0 || req1);
    grant     = take && !rst;
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_oor   = (64'(sel_addr) >= LIMIT) || (sel_addr[1:0] != 2'b00);

    gnt0         = grant && !win;
    gnt1         = grant && win;
    err          = grant && sel_oor;
    ram_en_store = grant && sel_we && !sel_oor;
    ram_en_fetch = grant && !sel_we && !sel_oor;
    ram_addr     = grant ? sel_addr[IDXW+1:2] : '0;
    ram_wdata    = grant ? sel_wdata : '0;

    rvalid0 = (state == RD_RESP) && !rd_port;
    rvalid1 = (state == RD_RESP) && rd_port;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_port <= 1'b0;
      rd_oor  <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take && !sel_we) begin
            state   <= RD_WAIT;
            rd_port <= win;
            rd_oor  <= sel_oor;
          end
        end
        RD_WAIT: begin
          // an out-of-range read never fetched, so it returns zero instead of stale RAM output
          if (rd_port) rdata1 <= rd_oor ? '0 : ram_rdata;
          else         rdata0 <= rd_oor ? '0 : ram_rdata;
          state <= RD_RESP;
        end
        RD_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written multi-cycle sequences,
// with read data checked through a scoreboard queue against a bench-side memory image.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1, err;
  logic [31:0] rdata0, rdata1;
  logic        ram_en_fetch, ram_en_store;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DWIDTH(32), .AWIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .err(err), .ram_en_fetch(ram_en_fetch), .ram_en_store(ram_en_store),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // data RAM with one-cycle registered read
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (ram_en_store) ram[ram_addr] <= ram_wdata;
    if (ram_en_fetch) ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [4:0]  exp_idx;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_mem [32];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic push(input logic p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_any_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
  endtask

  // read responses are matched in order against the scoreboard
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rvalid", {rvalid1, rvalid0}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_port", {rvalid1, rvalid0}, mon_e.port ? 2'b10 : 2'b01);
        check("rdata", mon_e.port ? rdata1 : rdata0, mon_e.data);
      end
    end
  end

  task automatic do_txn(input vec_t v);
    int n;
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    if (!v.we) push(v.port, v.exp_err ? 32'h0 : exp_mem[v.exp_idx]);
    wait_any_gnt(n);
    check("txn_grant_seen", n < 20, 1'b1);
    check("txn_outputs", {gnt0, gnt1, err, ram_en_store, ram_en_fetch},
          {!v.port, v.port, v.exp_err, v.we && !v.exp_err, !v.we && !v.exp_err});
    if (!v.exp_err) check("txn_ram_addr", ram_addr, v.exp_idx);
    if (v.we && !v.exp_err) check("txn_ram_wdata", ram_wdata, v.wdata);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    if (v.we && !v.exp_err) exp_mem[v.exp_idx] = v.wdata;
    if (!v.we) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(v.port ? rvalid1 : rvalid0) && n < 10);
      check("rvalid_latency", n, 2);
      @(negedge clk);
      check("rvalid_one_cycle", {rvalid1, rvalid0}, 2'b00);
    end
  endtask

  vec_t vecs[14];
  int   n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 32; i++) begin
      ram[i]     = 32'hC0DE_0000 | i;
      exp_mem[i] = 32'hC0DE_0000 | i;
    end
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 5'd2};
    vecs[1]  = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 5'd2};
    vecs[2]  = '{1'b1, 1'b1, 32'h0C, 32'h12345678, 1'b0, 5'd3};
    vecs[3]  = '{1'b0, 1'b0, 32'h0C, 32'h0,        1'b0, 5'd3};
    vecs[4]  = '{1'b1, 1'b0, 32'h08, 32'h0,        1'b0, 5'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h80, 32'h0,        1'b1, 5'd0};
    vecs[6]  = '{1'b1, 1'b1, 32'h06, 32'hBADBAD00, 1'b1, 5'd1};
    vecs[7]  = '{1'b1, 1'b0, 32'h04, 32'h0,        1'b0, 5'd1};
    vecs[8]  = '{1'b0, 1'b1, 32'h7C, 32'hA5A5A5A5, 1'b0, 5'd31};
    vecs[9]  = '{1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 5'd31};
    vecs[10] = '{1'b0, 1'b1, 32'h7D, 32'h5A5A5A5A, 1'b1, 5'd31};
    vecs[11] = '{1'b1, 1'b0, 32'h7E, 32'h0,        1'b1, 5'd31};
    vecs[12] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,  1'b1, 5'd31};
    vecs[13] = '{1'b0, 1'b0, 32'h7C, 32'h0,        1'b0, 5'd31};

    // reset state
    #3;
    check("rst_ctrl", {gnt0, gnt1, rvalid0, rvalid1, err, ram_en_fetch, ram_en_store, ram_addr}, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // simultaneous reads straight out of reset
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    push(1'b0, exp_mem[4]);
    @(negedge clk);
    check("sim_first_grant", {gnt0, gnt1}, 2'b10);
`ifdef DMEM_ARBITER_RR_EN
    push(1'b1, exp_mem[5]);
    wait_any_gnt(n);
    check("rr_second_grant", {gnt0, gnt1}, 2'b01);
    check("rr_grant_gap", n, 3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`else
    for (int unsigned k = 0; k < 2; k++) begin
      push(1'b0, exp_mem[4]);
      wait_any_gnt(n);
      check("fixed_port0_again", {gnt0, gnt1}, 2'b10);
      check("fixed_grant_gap", n, 3);
    end
    push(1'b1, exp_mem[5]);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_any_gnt(n);
    check("fixed_port1_after", {gnt0, gnt1}, 2'b01);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
    repeat (4) @(negedge clk);

    for (int unsigned i = 0; i < 14; i++) do_txn(vecs[i]);

    // back-to-back writes on port 1
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      addr1  = 32'(i * 4);
      wdata1 = 32'hB0B0_0000 | i;
      @(negedge clk);
      check("b2b_write", {gnt1, gnt0, ram_en_store, err, ram_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 5'(i)});
      check("b2b_wdata", ram_wdata, 32'hB0B0_0000 | i);
      exp_mem[i] = wdata1;
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_txn('{1'b0, 1'b0, 32'h04, 32'h0, 1'b0, 5'd1});

    // port 1 request held off during a port 0 read
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    push(1'b0, exp_mem[2]);
    wait_any_gnt(n);
    check("held_p0_grant", {gnt0, gnt1}, 2'b10);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h77777777);
    @(negedge clk);
    check("held_rd_wait", {gnt1, rvalid0, ram_en_store}, 3'b000);
    @(negedge clk);
    check("held_rd_resp", {gnt1, rvalid0, ram_en_store}, 3'b010);
    @(negedge clk);
    check("held_grant", {gnt1, ram_en_store, ram_addr}, {1'b1, 1'b1, 5'd4});
    exp_mem[4] = 32'h77777777;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // asynchronous reset while in RD_WAIT
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    push(1'b0, exp_mem[4]);
    wait_any_gnt(n);
    check("rst_case_grant", {gnt0, gnt1}, 2'b10);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("rst_abort_outputs", {rvalid0, rvalid1, gnt0, gnt1, err, ram_en_fetch, ram_en_store}, 0);
    check("rst_abort_rdata0", rdata0, 0);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_rvalid", {rvalid0, rvalid1}, 2'b00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    push(1'b0, exp_mem[4]);
    @(negedge clk);
    check("post_rst_grant", {gnt0, ram_en_fetch, ram_addr}, {1'b1, 1'b1, 5'd4});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid0 && n < 10);
    check("post_rst_rvalid_latency", n, 2);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
